debounce_multi: RTL
===================

Name: debounce_multi

Overview:
- Parametrised N-channel debouncer for push-buttons and switches in the calculator front end.
- Per channel:
  - synchronises the raw input;
  - debounces both press and release edges symmetrically;
  - emits a debounced level, one-cycle press and release strobes, and an optional typematic auto-repeat strobe.
- Sits between board pins and the key-decode/control FSM.

Parameters:
- N_CH, 5: number of independent input channels.
- DB_CYCLES, 1000000: consecutive stable synchronised cycles required to accept an edge; must be >= 1.
- SYNC_STAGES, 2: flip-flop synchroniser depth per channel; must be >= 2.
- REPEAT_EN, 1: 1 enables auto-repeat; 0 ties rpt to 0 and removes the repeat counters.
- REPEAT_DELAY, 50000000: cycles from deb rising to the first rpt pulse; must be >= 1.
- REPEAT_RATE, 10000000: cycles between subsequent rpt pulses; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- undeb  in  N_CH  raw asynchronous inputs, active-high.
- deb  out  N_CH  debounced level.
- press  out  N_CH  one-cycle strobe on the cycle deb rises.
- release  out  N_CH  one-cycle strobe on the cycle deb falls.
- rpt  out  N_CH  one-cycle auto-repeat strobe while held.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset:
  - all synchroniser flops, counters and outputs go to 0; all channels go to DB_IDLE.
  - Reset mid-operation aborts silently: no release strobe is generated, and deb = 0 after the reset edge.
- Channels are fully independent and share no state. Simultaneous events on different channels produce strobes in the same cycle.
- s = last synchroniser stage output.
- dcnt = debounce counter, width $clog2(DB_CYCLES+1), saturating.
- Per-channel registered FSM:
  - DB_IDLE: deb = 0.
    - s = 1 -> DB_ARM_HI, dcnt <= 1.
  - DB_ARM_HI: deb = 0.
    - s = 0 -> DB_IDLE, dcnt <= 0.
    - s = 1 and dcnt == DB_CYCLES -> DB_HELD; deb = 1 and press = 1 on the next cycle.
    - Otherwise dcnt++.
  - DB_HELD: deb = 1.
    - s = 0 -> DB_ARM_LO, dcnt <= 1.
    - The repeat counter runs.
  - DB_ARM_LO: deb = 1.
    - s = 1 -> DB_HELD, dcnt <= 0; the repeat counter resumes from its held value.
    - s = 0 and dcnt == DB_CYCLES -> DB_IDLE; deb = 0 and release = 1 on the next cycle.
    - Otherwise dcnt++.
    - The repeat counter is frozen; no rpt is emitted.
- Latency:
  - undeb stable from before edge E0 -> deb and press change after edge E0 + SYNC_STAGES + DB_CYCLES.
  - Release is symmetric.
  - A bounce shorter than DB_CYCLES synchronised cycles produces no output change.
- Strobes:
  - press, release and rpt are registered and high for exactly one cycle.
  - press and rpt are never high in the same cycle.
  - press and release are never high on the same channel in the same cycle.
- Auto-repeat (REPEAT_EN = 1):
  - rcnt is cleared on entry to DB_HELD from DB_ARM_HI and counts cycles spent in DB_HELD.
  - First rpt occurs REPEAT_DELAY cycles after deb rises.
  - Subsequent rpt pulses occur every REPEAT_RATE cycles.
  - rcnt reloads on each pulse and never overflows.
- DB_CYCLES = 1: an edge is accepted after one stable synchronised cycle; the FSM still passes through the ARM state.

Decomposition:
- Package debounce_pkg holds:
  - enum deb_state_t {DB_IDLE, DB_ARM_HI, DB_HELD, DB_ARM_LO};
  - a counter-width helper function;
  - parameter-legality checks (static assertions).
- Sub-module debounce_ch contains one channel: synchroniser, FSM, dcnt and rcnt.
- debounce_multi is a generate loop of N_CH debounce_ch instances plus port packing.

Test Plan:
- Common bench parameters: N_CH=4, DB_CYCLES=4, SYNC_STAGES=2, REPEAT_DELAY=10, REPEAT_RATE=3.
- Clean press: undeb[0] rises before edge 0 and is held -> deb[0] = 1 and press[0] = 1 after edge 6; press[0] = 0 after edge 7; channels 1-3 stay 0.
- Bouncy press: undeb[1] toggles every 2 cycles for 20 cycles, then stays high -> no deb or press during toggling; exactly one press[1], 6 edges after the final rise.
- Release glitch and release:
  - while held, a 2-cycle low pulse on undeb[2] -> deb[2] stays 1, no release;
  - sustained low -> release[2] pulse and deb[2] = 0, 6 edges after the fall.
- Auto-repeat: hold undeb[0] 30 cycles past deb rise -> rpt[0] pulses at cycles 10, 13, 16, 19, 22, 25, 28 relative to deb rise; none after release begins.
- Simultaneous channels: undeb[0] and undeb[3] rise on the same cycle -> press[0] and press[3] in the same cycle; deb[1] and deb[2] stay 0.
- Reset mid-hold: assert rst for 1 cycle while deb[1] = 1 -> all outputs 0 after that edge, no release strobe; continued high input re-presses after a full 6-edge latency. Also repeat with REPEAT_EN = 0 -> rpt stays 0 throughout.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel debouncer.
// Imported by debounce_ch and debounce_multi.
package debounce_pkg;

  typedef enum logic [1:0] {
    DB_IDLE   = 2'd0,
    DB_ARM_HI = 2'd1,
    DB_HELD   = 2'd2,
    DB_ARM_LO = 2'd3
  } deb_state_t;

  // Bits needed to hold every value in 0..max_val (never less than 1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic bit params_legal(input int db_cycles, input int sync_stages,
                                      input int repeat_delay, input int repeat_rate);
    return (db_cycles >= 1) && (sync_stages >= 2) &&
           (repeat_delay >= 1) && (repeat_rate >= 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debouncer channel: input synchroniser, symmetric press/release debounce FSM
// and optional typematic repeat. The release strobe is named rel because release is a reserved word.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES    = 1000000,
  parameter int SYNC_STAGES  = 2,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic undeb,
  output logic deb,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int DW = cnt_width(DB_CYCLES);
  localparam logic [DW-1:0] DB_MAX = DW'(DB_CYCLES);

  if (!params_legal(DB_CYCLES, SYNC_STAGES, REPEAT_DELAY, REPEAT_RATE)) begin : g_bad_params
    $error("debounce_ch: DB_CYCLES, REPEAT_DELAY, REPEAT_RATE must be >= 1 and SYNC_STAGES >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  deb_state_t             state_reg, state_next;
  logic [DW-1:0]          dcnt_reg, dcnt_next;
  logic                   deb_reg, deb_next;
  logic                   press_reg, press_next;
  logic                   rel_reg, rel_next;
  logic                   held_entry;
  logic                   held_stay;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], undeb};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= DB_IDLE;
      dcnt_reg  <= '0;
      deb_reg   <= 1'b0;
      press_reg <= 1'b0;
      rel_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      dcnt_reg  <= dcnt_next;
      deb_reg   <= deb_next;
      press_reg <= press_next;
      rel_reg   <= rel_next;
    end
  end

  // Both ARM states count consecutive cycles at the new level; any return aborts the edge.
  always_comb begin
    state_next = state_reg;
    dcnt_next  = dcnt_reg;
    press_next = 1'b0;
    rel_next   = 1'b0;
    held_entry = 1'b0;
    held_stay  = 1'b0;
    case (state_reg)
      DB_IDLE: begin
        if (s) begin
          state_next = DB_ARM_HI;
          dcnt_next  = DW'(1);
        end
      end
      DB_ARM_HI: begin
        if (!s) begin
          state_next = DB_IDLE;
          dcnt_next  = '0;
        end else if (dcnt_reg == DB_MAX) begin
          state_next = DB_HELD;
          dcnt_next  = '0;
          press_next = 1'b1;
          held_entry = 1'b1;
        end else if (dcnt_reg != DB_MAX) begin
          dcnt_next = dcnt_reg + DW'(1);
        end
      end
      DB_HELD: begin
        if (!s) begin
          state_next = DB_ARM_LO;
          dcnt_next  = DW'(1);
        end else begin
          held_stay = 1'b1;
        end
      end
      DB_ARM_LO: begin
        if (s) begin
          state_next = DB_HELD;
          dcnt_next  = '0;
        end else if (dcnt_reg == DB_MAX) begin
          state_next = DB_IDLE;
          dcnt_next  = '0;
          rel_next   = 1'b1;
        end else begin
          dcnt_next = dcnt_reg + DW'(1);
        end
      end
      default: begin
        state_next = DB_IDLE;
        dcnt_next  = '0;
      end
    endcase
  end

  assign deb_next = (state_next == DB_HELD) || (state_next == DB_ARM_LO);
  assign deb      = deb_reg;
  assign press    = press_reg;
  assign rel      = rel_reg;

  if (REPEAT_EN != 0) begin : g_rpt
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = cnt_width(RMAX);

    logic [RW-1:0] rcnt_reg;
    logic [RW-1:0] rcnt_limit;
    logic          first_done_reg;
    logic          rpt_reg;

    // The first interval is measured from the press, later ones from the previous pulse.
    assign rcnt_limit = first_done_reg ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1);

    always_ff @(posedge clk) begin
      if (rst) begin
        rcnt_reg       <= '0;
        first_done_reg <= 1'b0;
        rpt_reg        <= 1'b0;
      end else begin
        rpt_reg <= 1'b0;
        if (held_entry) begin
          rcnt_reg       <= '0;
          first_done_reg <= 1'b0;
        end else if (held_stay) begin
          if (rcnt_reg == rcnt_limit) begin
            rcnt_reg       <= '0;
            first_done_reg <= 1'b1;
            rpt_reg        <= 1'b1;
          end else begin
            rcnt_reg <= rcnt_reg + RW'(1);
          end
        end
      end
    end

    assign rpt = rpt_reg;
  end else begin : g_no_rpt
    logic unused_rpt_ctl;
    assign unused_rpt_ctl = held_entry ^ held_stay;
    assign rpt            = 1'b0;
  end

endmodule

// File: rtl/debounce_multi.sv
// N-channel push-button/switch debouncer: independent debounce_ch instances
// packed onto vector ports. rel[i] is the one-cycle release strobe of channel i.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH         = 5,
  parameter int DB_CYCLES    = 1000000,
  parameter int SYNC_STAGES  = 2,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] undeb,
  output logic [N_CH-1:0] deb,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel,
  output logic [N_CH-1:0] rpt
);

  if (N_CH < 1) begin : g_bad_nch
    $error("debounce_multi: N_CH must be >= 1");
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      debounce_ch #(
        .DB_CYCLES   (DB_CYCLES),
        .SYNC_STAGES (SYNC_STAGES),
        .REPEAT_EN   (REPEAT_EN),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
      ) u_ch (
        .clk  (clk),
        .rst  (rst),
        .undeb(undeb[gi]),
        .deb  (deb[gi]),
        .press(press[gi]),
        .rel  (rel[gi]),
        .rpt  (rpt[gi])
      );
    end
  endgenerate

endmodule
